// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader: word width and loader state encoding.
package fir_pkg;

    localparam int COEFF_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } loader_state_t;

endpackage

// File: rtl/fir_coeff_loader.sv
// Collects N coefficient words into a shadow register and commits them atomically to the FIR stage.
// Optional feature macro FIR_COEFF_CHECKSUM_EN adds a modulo-2^16 checksum of the committed set.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 coeff_valid,
    output logic                 coeff_ready,
    input  logic [COEFF_W-1:0]   coeff_data,
    input  logic                 coeff_last,
    output logic [N*COEFF_W-1:0] coeff_out,
    output logic                 load,
    output logic                 busy,
    output logic                 err
`ifdef FIR_COEFF_CHECKSUM_EN
    ,
    output logic [COEFF_W-1:0]   checksum
`endif
);

    localparam int IDX_W = $clog2(N) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    loader_state_t state, next_state;
    logic [IDX_W-1:0]   index;
    logic [N*COEFF_W-1:0] shadow;
    logic [N*COEFF_W-1:0] full_set;
    logic accept, restart, commit, frame_err;

    // The final word bypasses the shadow so the commit lands on the same edge as the handshake.
    assign full_set = {coeff_data, shadow[(N-1)*COEFF_W-1:0]};
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        coeff_ready = 1'b0;
        load        = 1'b0;
        accept      = 1'b0;
        restart     = 1'b0;
        commit      = 1'b0;
        frame_err   = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = FILL;
            end
            FILL: begin
                coeff_ready = 1'b1;
                if (start) begin
                    restart = 1'b1;
                end else if (coeff_valid) begin
                    accept = 1'b1;
                    if (coeff_last && index == LAST_IDX) begin
                        commit     = 1'b1;
                        next_state = COMMIT;
                    end else if (coeff_last || index == LAST_IDX) begin
                        frame_err  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            COMMIT: begin
                load       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index     <= '0;
            shadow    <= '0;
            coeff_out <= '0;
            err       <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                index <= '0;
                err   <= 1'b0;
            end
            if (restart) begin
                index  <= '0;
                shadow <= '0;
            end
            if (accept) begin
                for (int k = 0; k < N; k++) begin
                    if (index == IDX_W'(k)) shadow[k*COEFF_W +: COEFF_W] <= coeff_data;
                end
                index <= index + 1'b1;
            end
            if (commit) begin
                coeff_out <= full_set;
                index     <= '0;
            end
            if (frame_err) begin
                err    <= 1'b1;
                index  <= '0;
                shadow <= '0;
            end
        end
    end

`ifdef FIR_COEFF_CHECKSUM_EN
    function automatic logic [COEFF_W-1:0] word_sum(input logic [N*COEFF_W-1:0] set);
        logic [COEFF_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < N; k++) acc = acc + set[k*COEFF_W +: COEFF_W];
        return acc;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (commit) begin
            checksum <= word_sum(full_set);
        end
    end
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized and directed bench for fir_coeff_loader (N=4) against a word-queue reference model.
module tb_fir_coeff_loader;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          coeff_valid = 1'b0;
    logic          coeff_ready;
    logic [15:0]   coeff_data = '0;
    logic          coeff_last = 1'b0;
    logic [N*16-1:0] coeff_out;
    logic          load;
    logic          busy;
    logic          err;
`ifdef FIR_COEFF_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    fir_coeff_loader #(.N(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .coeff_valid(coeff_valid),
        .coeff_ready(coeff_ready),
        .coeff_data(coeff_data),
        .coeff_last(coeff_last),
        .coeff_out(coeff_out),
        .load(load),
        .busy(busy),
        .err(err)
`ifdef FIR_COEFF_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int load_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = waiting for start, 1 = collecting words, 2 = load cycle
    int          m_mode = 0;
    logic [15:0] m_q[$];
    logic [N*16-1:0] m_out = '0;
    logic        m_err = 1'b0;
    logic [15:0] m_sum = '0;

    always @(negedge rst_n) begin
        m_mode = 0;
        m_q.delete();
        m_out = '0;
        m_err = 1'b0;
        m_sum = '0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0;
            m_q.delete();
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode = 1;
                    m_q.delete();
                    m_err = 1'b0;
                end
                1: if (start) begin
                    m_q.delete();
                end else if (coeff_valid) begin
                    m_q.push_back(coeff_data);
                    if (coeff_last && m_q.size() == N) begin
                        m_sum = '0;
                        for (int k = 0; k < N; k++) begin
                            m_out[k*16 +: 16] = m_q[k];
                            m_sum = m_sum + m_q[k];
                        end
                        m_mode = 2;
                    end else if (coeff_last || m_q.size() == N) begin
                        m_err = 1'b1;
                        m_mode = 0;
                    end
                end
                default: m_mode = 0;
            endcase
            #2;
            if (rst_n) begin
                check("coeff_ready", 64'(coeff_ready), 64'(m_mode == 1));
                check("load", 64'(load), 64'(m_mode == 2));
                check("busy", 64'(busy), 64'(m_mode != 0));
                check("err", 64'(err), 64'(m_err));
                check("coeff_out", coeff_out, m_out);
`ifdef FIR_COEFF_CHECKSUM_EN
                check("checksum", 64'(checksum), 64'(m_sum));
`endif
                if (load) load_cnt++;
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        coeff_valid = 1'b1;
        coeff_data  = d;
        coeff_last  = l;
        @(negedge clk);
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int lc;
        #1;
        check("reset coeff_out", coeff_out, 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset ready", 64'(coeff_ready), 64'h0);
        check("reset load", 64'(load), 64'h0);
        check("reset err", 64'(err), 64'h0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Basic commit 1,2,3,4
        lc = load_cnt;
        do_start();
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        send(16'h0004, 1'b1);
        check("commit load", 64'(load), 64'h1);
        check("commit out", coeff_out, 64'h0004_0003_0002_0001);
        check("commit err", 64'(err), 64'h0);
        idle(3);
        check("commit pulses", 64'(load_cnt - lc), 64'h1);

        // Early last
        lc = load_cnt;
        do_start();
        send(16'h0011, 1'b0);
        send(16'h0022, 1'b1);
        check("early err", 64'(err), 64'h1);
        check("early busy", 64'(busy), 64'h0);
        idle(3);
        check("early out", coeff_out, 64'h0004_0003_0002_0001);
        check("early pulses", 64'(load_cnt - lc), 64'h0);

        // Missing last
        do_start();
        for (int i = 0; i < 4; i++) send(16'(16'h0100 + i), 1'b0);
        check("nolast err", 64'(err), 64'h1);
        check("nolast busy", 64'(busy), 64'h0);
        check("nolast out", coeff_out, 64'h0004_0003_0002_0001);
        idle(2);

        // Restart mid-fill, start during COMMIT ignored
        lc = load_cnt;
        do_start();
        send(16'h0055, 1'b0);
        send(16'h0066, 1'b0);
        coeff_valid = 1'b1;
        coeff_data  = 16'h0099;
        do_start();
        coeff_valid = 1'b0;
        send(16'h000A, 1'b0);
        send(16'h000B, 1'b0);
        send(16'h000C, 1'b0);
        send(16'h000D, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart busy", 64'(busy), 64'h0);
        check("restart out", coeff_out, 64'h000D_000C_000B_000A);
        check("restart err", 64'(err), 64'h0);
        idle(2);
        check("restart pulses", 64'(load_cnt - lc), 64'h1);

`ifdef FIR_COEFF_CHECKSUM_EN
        do_start();
        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        send(16'h0004, 1'b1);
        check("checksum wrap", 64'(checksum), 64'h0008);
        idle(2);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            start       = ($urandom_range(0, 15) == 0);
            coeff_valid = ($urandom_range(0, 1) == 1);
            coeff_data  = 16'($urandom);
            if (m_q.size() == N - 1) coeff_last = ($urandom_range(0, 7) != 0);
            else                     coeff_last = ($urandom_range(0, 9) == 0);
            if (m_mode == 0 && $urandom_range(0, 2) == 0) start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        coeff_valid = 1'b0;
        coeff_last = 1'b0;
        idle(2);

        // Asynchronous reset mid-fill
        lc = load_cnt;
        do_start();
        send(16'h0123, 1'b0);
        send(16'h0456, 1'b0);
        send(16'h0789, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst coeff_out", coeff_out, 64'h0);
        check("arst busy", 64'(busy), 64'h0);
        check("arst ready", 64'(coeff_ready), 64'h0);
        check("arst load", 64'(load), 64'h0);
        check("arst err", 64'(err), 64'h0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check("arst pulses", 64'(load_cnt - lc), 64'h0);
        check("arst idle", 64'(busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
